// File: rtl/pc_pkg.sv
// pc_pkg: state encoding and default addresses shared by the program-counter unit
package pc_pkg;
    typedef enum logic [1:0] {PC_HALT = 2'd0, PC_RUN = 2'd1, PC_STEP = 2'd2} pc_state_e;
    localparam int BP_EN_BIT = 0;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_WRAP_ADDR = 32'h0000_0048;
endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl_if: core-side and debug-side signals of the program-counter unit
interface pc_ctrl_if #(parameter int XLEN = 32, parameter int NUM_BP = 2);
    localparam int IW = NUM_BP > 1 ? $clog2(NUM_BP) : 1;
    logic            run_i;
    logic            step_i;
    logic            stall_i;
    logic            wrap_en_i;
    logic [XLEN-1:0] npc_i;
    logic            bp_we_i;
    logic [IW-1:0]   bp_idx_i;
    logic [XLEN-1:0] bp_addr_i;
    logic [XLEN-1:0] pc_o;
    logic [1:0]      state_o;
    logic            bp_hit_o;
    logic [2:0]      bp_hit_idx_o;
    logic [31:0]     retire_cnt_o;
    modport master (output run_i, step_i, stall_i, wrap_en_i, npc_i, bp_we_i, bp_idx_i, bp_addr_i,
                    input pc_o, state_o, bp_hit_o, bp_hit_idx_o, retire_cnt_o);
    modport slave  (input run_i, step_i, stall_i, wrap_en_i, npc_i, bp_we_i, bp_idx_i, bp_addr_i,
                    output pc_o, state_o, bp_hit_o, bp_hit_idx_o, retire_cnt_o);
endinterface

// File: rtl/pc_bp_match.sv
// pc_bp_match: breakpoint register bank with lowest-index-wins comparator
module pc_bp_match import pc_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int NUM_BP = 2,
    parameter int IW     = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            we_i,
    input  logic [IW-1:0]   idx_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] nv_i,
    output logic            hit_o,
    output logic [2:0]      idx_o
);
    logic [XLEN-1:0] bp_q [NUM_BP];

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        always_ff @(posedge clk or negedge rstn)
            if (!rstn) bp_q[i] <= '0;
            else if (we_i && idx_i == IW'(i)) bp_q[i] <= addr_i;
    end

    // Descending scan so the lowest matching index is the one left standing
    always_comb begin
        hit_o = 1'b0;
        idx_o = 3'd0;
        for (int k = NUM_BP - 1; k >= 0; k--)
            if (bp_q[k][BP_EN_BIT] && ((bp_q[k] ^ nv_i) & ~XLEN'(3)) == '0) begin
                hit_o = 1'b1;
                idx_o = 3'(k);
            end
    end
endmodule

// File: rtl/pc_ctrl.sv
// pc_ctrl: program counter with RUN/HALT/STEP control, wrap redirect and breakpoints.
// Define PC_RETIRE_CNT_EN to build the retire counter behind retire_cnt_o.
module pc_ctrl import pc_pkg::*; #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] WRAP_ADDR = XLEN'(DEF_WRAP_ADDR),
    parameter int              NUM_BP    = 2,
    parameter bit              START_RUN = 1'b1
) (
    input logic       clk,
    input logic       rstn,
    pc_ctrl_if.slave  bus
);
    localparam int IW = NUM_BP > 1 ? $clog2(NUM_BP) : 1;

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, sel, nv;
    logic [1:0]      run_s_q, step_s_q;
    logic            run_p_q, step_p_q, run_rise, step_rise, adv, hit;
    logic            bp_hit_q, bp_hit_d;
    logic [2:0]      hit_idx, bp_idx_q, bp_idx_d;

    assign run_rise  = run_s_q[1] & ~run_p_q;
    assign step_rise = step_s_q[1] & ~step_p_q;
    assign sel       = (bus.wrap_en_i && bus.npc_i == WRAP_ADDR) ? RESET_VEC : bus.npc_i;
    assign nv        = sel & ~XLEN'(3);

    pc_bp_match #(.XLEN(XLEN), .NUM_BP(NUM_BP), .IW(IW)) u_bp (
        .clk    (clk),
        .rstn   (rstn),
        .we_i   (bus.bp_we_i),
        .idx_i  (bus.bp_idx_i),
        .addr_i (bus.bp_addr_i),
        .nv_i   (nv),
        .hit_o  (hit),
        .idx_o  (hit_idx)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state_q <= START_RUN ? PC_RUN : PC_HALT;
        else state_q <= state_d;

    // Run edge is checked before step edge so a simultaneous request resumes
    always_comb begin
        state_d = (state_q == PC_RUN)  ? ((!run_s_q[1] || (adv && hit)) ? PC_HALT : PC_RUN) :
                  (state_q == PC_STEP) ? (adv ? PC_HALT : PC_STEP) :
                  run_rise ? PC_RUN : step_rise ? PC_STEP : PC_HALT;
    end

    always_comb begin
        adv      = (state_q == PC_RUN || state_q == PC_STEP) && !bus.stall_i;
        pc_d     = adv ? nv : pc_q;
        bp_hit_d = (state_q == PC_RUN && adv && hit) ? 1'b1 :
                   (state_q == PC_HALT && state_d != PC_HALT) ? 1'b0 : bp_hit_q;
        bp_idx_d = (state_q == PC_RUN && adv && hit) ? hit_idx : bp_idx_q;
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            pc_q     <= RESET_VEC & ~XLEN'(3);
            run_s_q  <= 2'b00;
            step_s_q <= 2'b00;
            run_p_q  <= 1'b0;
            step_p_q <= 1'b0;
            bp_hit_q <= 1'b0;
            bp_idx_q <= 3'd0;
        end else begin
            pc_q     <= pc_d;
            run_s_q  <= {run_s_q[0], bus.run_i};
            step_s_q <= {step_s_q[0], bus.step_i};
            run_p_q  <= run_s_q[1];
            step_p_q <= step_s_q[1];
            bp_hit_q <= bp_hit_d;
            bp_idx_q <= bp_idx_d;
        end

`ifdef PC_RETIRE_CNT_EN
    logic [31:0] cnt_q;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) cnt_q <= 32'd0;
        else cnt_q <= cnt_q + {31'd0, adv};
    assign bus.retire_cnt_o = cnt_q;
`else
    assign bus.retire_cnt_o = 32'd0;
`endif

    assign bus.pc_o         = pc_q;
    assign bus.state_o      = state_q;
    assign bus.bp_hit_o     = bp_hit_q;
    assign bus.bp_hit_idx_o = bp_idx_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed-vector bench for pc_ctrl with hand-traced expected values
module tb_pc_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    pc_ctrl_if #(.XLEN(32), .NUM_BP(2)) bus ();

    pc_ctrl #(.XLEN(32), .RESET_VEC(32'h0), .WRAP_ADDR(32'h48), .NUM_BP(2), .START_RUN(1'b1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.npc_i = bus.pc_o + 32'd4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bp_wr(input logic idx, input logic [31:0] addr);
        bus.bp_we_i   = 1'b1;
        bus.bp_idx_i  = idx;
        bus.bp_addr_i = addr;
        cyc(1);
        bus.bp_we_i   = 1'b0;
    endtask

    initial begin
        bus.run_i = 1'b1;
        bus.step_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.wrap_en_i = 1'b1;
        bus.bp_we_i = 1'b0;
        bus.bp_idx_i = 1'b0;
        bus.bp_addr_i = 32'h0;
        cyc(3);
        chk("rst_pc", bus.pc_o, 32'h0);
        chk("rst_state", bus.state_o, 32'd1);
        chk("rst_hit", bus.bp_hit_o, 32'd0);
        chk("rst_idx", bus.bp_hit_idx_o, 32'd0);
        chk("rst_cnt", bus.retire_cnt_o, 32'd0);
        rstn = 1'b1;
        // synchroniser still 0 for two cycles: one advance, halt, then resume on the run edge
        cyc(1);
        chk("boot_pc", bus.pc_o, 32'h4);
        chk("boot_halt", bus.state_o, 32'd0);
        cyc(2);
        chk("boot_run", bus.state_o, 32'd1);
        chk("boot_pc2", bus.pc_o, 32'h4);
        cyc(3);
        chk("run_pc10", bus.pc_o, 32'h10);
        bus.stall_i = 1'b1;
        cyc(3);
        chk("stall_hold", bus.pc_o, 32'h10);
        bus.stall_i = 1'b0;
        cyc(1);
        chk("stall_rel", bus.pc_o, 32'h14);
        cyc(12);
        chk("pc_44", bus.pc_o, 32'h44);
        cyc(1);
        chk("wrap", bus.pc_o, 32'h0);
        bus.wrap_en_i = 1'b0;
        cyc(18);
        chk("nowrap_48", bus.pc_o, 32'h48);
        cyc(1);
        chk("nowrap_4c", bus.pc_o, 32'h4c);
`ifdef PC_RETIRE_CNT_EN
        chk("cnt_37", bus.retire_cnt_o, 32'd37);
`else
        chk("cnt_tied", bus.retire_cnt_o, 32'd0);
`endif
        rstn = 1'b0;
        bus.run_i = 1'b0;
        cyc(2);
        rstn = 1'b1;
        cyc(1);
        chk("rst2_halt", bus.state_o, 32'd0);
        chk("rst2_pc", bus.pc_o, 32'h4);
        bp_wr(1'b0, 32'h21);
        bp_wr(1'b1, 32'h31);
        bus.run_i = 1'b1;
        cyc(9);
        chk("bp_pre_pc", bus.pc_o, 32'h1c);
        chk("bp_pre_hit", bus.bp_hit_o, 32'd0);
        cyc(1);
        chk("bp0_pc", bus.pc_o, 32'h20);
        chk("bp0_state", bus.state_o, 32'd0);
        chk("bp0_hit", bus.bp_hit_o, 32'd1);
        chk("bp0_idx", bus.bp_hit_idx_o, 32'd0);
        cyc(5);
        chk("bp_hold_pc", bus.pc_o, 32'h20);
        chk("bp_hold_st", bus.state_o, 32'd0);
        bus.run_i = 1'b0;
        cyc(3);
        bus.run_i = 1'b1;
        cyc(3);
        chk("resume_st", bus.state_o, 32'd1);
        chk("resume_hit", bus.bp_hit_o, 32'd0);
        cyc(1);
        chk("resume_pc", bus.pc_o, 32'h24);
        cyc(3);
        chk("bp1_pc", bus.pc_o, 32'h30);
        chk("bp1_hit", bus.bp_hit_o, 32'd1);
        chk("bp1_idx", bus.bp_hit_idx_o, 32'd1);
        bus.step_i = 1'b1;
        cyc(2);
        chk("step_wait_st", bus.state_o, 32'd0);
        chk("step_wait_pc", bus.pc_o, 32'h30);
        cyc(1);
        chk("step_st", bus.state_o, 32'd2);
        chk("step_hitclr", bus.bp_hit_o, 32'd0);
        cyc(1);
        chk("step_pc", bus.pc_o, 32'h34);
        chk("step_done", bus.state_o, 32'd0);
        cyc(1);
        chk("step_once", bus.pc_o, 32'h34);
        bus.step_i = 1'b0;
        bus.run_i = 1'b0;
        cyc(4);
        bus.run_i = 1'b1;
        bus.step_i = 1'b1;
        cyc(3);
        chk("race_run", bus.state_o, 32'd1);
        cyc(1);
        chk("race_pc", bus.pc_o, 32'h38);
        bus.stall_i = 1'b1;
        bus.run_i = 1'b0;
        bus.step_i = 1'b0;
        cyc(3);
        chk("stall_halt", bus.state_o, 32'd0);
        bus.step_i = 1'b1;
        cyc(3);
        chk("stall_step", bus.state_o, 32'd2);
        cyc(2);
        chk("step_stalled", bus.state_o, 32'd2);
        chk("step_st_pc", bus.pc_o, 32'h38);
        rstn = 1'b0;
        #1;
        chk("abort_pc", bus.pc_o, 32'h0);
        chk("abort_st", bus.state_o, 32'd1);
        chk("abort_hit", bus.bp_hit_o, 32'd0);
        chk("abort_cnt", bus.retire_cnt_o, 32'd0);
        bus.step_i = 1'b0;
        bus.stall_i = 1'b0;
        bus.run_i = 1'b1;
        cyc(2);
        rstn = 1'b1;
        cyc(11);
        chk("bp_clr_pc", bus.pc_o, 32'h24);
        chk("bp_clr_st", bus.state_o, 32'd1);
        chk("bp_clr_hit", bus.bp_hit_o, 32'd0);
`ifdef PC_RETIRE_CNT_EN
        chk("cnt_9", bus.retire_cnt_o, 32'd9);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
